// File: rtl/img_mem_arbiter.sv
// Arbitrates the single-port image RAM: display has absolute priority, read/write share the rest round-robin.
// Latency: RAM command one edge after the request, read data two edges after it; display never waits.
module img_mem_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_q,
    output logic              disp_valid,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q,
    output logic [15:0]       conflict_cnt
);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(IMG_WIDTH * IMG_HEIGHT);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_RD   = 2'd2
    } tag_kind_e;

    typedef struct packed {
        tag_kind_e kind;
        logic      zero;
    } tag_t;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rd_ack_q, rd_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              last_wr_q, last_wr_d;
    tag_t              tag1_q, tag1_d;
    tag_t              tag2_q, tag2_d;
    logic [DATA_W-1:0] disp_pix_q, disp_pix_d;
    logic [DATA_W-1:0] rd_pix_q, rd_pix_d;
    logic              disp_valid_q, disp_valid_d;
    logic              rd_valid_q, rd_valid_d;
    logic [15:0]       conflict_cnt_q, conflict_cnt_d;
    logic              grant_rd, grant_wr;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        // last_wr_q high means the write port won last, so a contested cycle goes to read
        grant_rd    = !disp_req && rd_req && (!wr_req || last_wr_q);
        grant_wr    = !disp_req && wr_req && !grant_rd;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rd_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
        last_wr_d   = last_wr_q;
        tag1_d.kind = TAG_NONE;
        tag1_d.zero = 1'b0;
        if (disp_req) begin
            mem_addr_d  = disp_addr;
            tag1_d.kind = TAG_DISP;
            tag1_d.zero = disp_addr >= ADDR_END;
        end else if (grant_rd) begin
            mem_addr_d  = rd_addr;
            rd_ack_d    = 1'b1;
            last_wr_d   = 1'b0;
            tag1_d.kind = TAG_RD;
            tag1_d.zero = rd_addr >= ADDR_END;
        end else if (grant_wr) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            mem_we_d    = wr_addr < ADDR_END;
            wr_ack_d    = 1'b1;
            last_wr_d   = 1'b1;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (disp_req && (rd_req || wr_req) && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end

        tag2_d       = tag1_q;
        ret_data     = tag2_q.zero ? '0 : mem_q;
        disp_valid_d = tag2_q.kind == TAG_DISP;
        rd_valid_d   = tag2_q.kind == TAG_RD;
        disp_pix_d   = disp_valid_d ? ret_data : disp_pix_q;
        rd_pix_d     = rd_valid_d ? ret_data : rd_pix_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            rd_ack_q       <= 1'b0;
            wr_ack_q       <= 1'b0;
            last_wr_q      <= 1'b1;
            tag1_q.kind    <= TAG_NONE;
            tag1_q.zero    <= 1'b0;
            tag2_q.kind    <= TAG_NONE;
            tag2_q.zero    <= 1'b0;
            disp_pix_q     <= '0;
            rd_pix_q       <= '0;
            disp_valid_q   <= 1'b0;
            rd_valid_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_wdata_q    <= mem_wdata_d;
            rd_ack_q       <= rd_ack_d;
            wr_ack_q       <= wr_ack_d;
            last_wr_q      <= last_wr_d;
            tag1_q         <= tag1_d;
            tag2_q         <= tag2_d;
            disp_pix_q     <= disp_pix_d;
            rd_pix_q       <= rd_pix_d;
            disp_valid_q   <= disp_valid_d;
            rd_valid_q     <= rd_valid_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign rd_ack       = rd_ack_q;
    assign wr_ack       = wr_ack_q;
    assign disp_q       = disp_pix_q;
    assign disp_valid   = disp_valid_q;
    assign rd_data      = rd_pix_q;
    assign rd_valid     = rd_valid_q;
    assign conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_img_mem_arbiter.sv
// Bench for img_mem_arbiter: an ideal-memory transaction model checks every cycle,
// directed scenarios pin literal values, then randomized traffic with occasional resets.
module tb_img_mem_arbiter;
    localparam int IMG_PIX = 160000;

    logic        clk;
    logic        rst;
    logic        disp_req;
    logic [17:0] disp_addr;
    logic [7:0]  disp_q;
    logic        disp_valid;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_q;
    logic [15:0] conflict_cnt;

    int tests = 0;
    int fails = 0;

    img_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_q(disp_q), .disp_valid(disp_valid),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_q(mem_q),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, preloaded with value = addr[7:0]
    logic [7:0] ram [0:262143];
    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'(i);
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: ideal image memory + return queue ----------------
    typedef struct {
        int         due;
        bit         disp;
        logic [7:0] data;
    } ret_t;

    logic [7:0]  shadow [0:IMG_PIX-1];
    ret_t        ret_q[$];
    ret_t        r;
    int          cyc = 0;
    bit          m_last_wr;
    logic [17:0] e_addr;
    logic [7:0]  e_wdata, e_disp_q, e_rd_data;
    bit          e_we, e_rd_ack, e_wr_ack, e_disp_valid, e_rd_valid;
    int          e_cnt;

    initial begin
        for (int i = 0; i < IMG_PIX; i++) shadow[i] = 8'(i);
    end

    function automatic logic [7:0] img_read(input logic [17:0] a);
        if (int'(a) < IMG_PIX) return shadow[int'(a)];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_last_wr = 1'b1;
            e_addr = '0; e_wdata = '0; e_we = 0; e_rd_ack = 0; e_wr_ack = 0;
            e_disp_q = '0; e_rd_data = '0; e_disp_valid = 0; e_rd_valid = 0; e_cnt = 0;
            ret_q.delete();
        end else begin
            e_disp_valid = 0;
            e_rd_valid = 0;
            while (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                r = ret_q.pop_front();
                if (r.disp) begin e_disp_q = r.data; e_disp_valid = 1; end
                else begin e_rd_data = r.data; e_rd_valid = 1; end
            end
            e_we = 0; e_rd_ack = 0; e_wr_ack = 0;
            if (disp_req && (rd_req || wr_req) && e_cnt < 65535) e_cnt++;
            if (disp_req) begin
                e_addr = disp_addr;
                ret_q.push_back('{due: cyc + 2, disp: 1'b1, data: img_read(disp_addr)});
            end else if (rd_req && (!wr_req || m_last_wr)) begin
                e_addr = rd_addr;
                e_rd_ack = 1;
                m_last_wr = 0;
                ret_q.push_back('{due: cyc + 2, disp: 1'b0, data: img_read(rd_addr)});
            end else if (wr_req) begin
                e_addr = wr_addr;
                e_wdata = wr_data;
                e_wr_ack = 1;
                m_last_wr = 1;
                if (int'(wr_addr) < IMG_PIX) begin
                    e_we = 1;
                    shadow[int'(wr_addr)] = wr_data;
                end
            end
        end
        cyc++;
        #1;
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        chk("rd_ack", 32'(rd_ack), 32'(e_rd_ack));
        chk("wr_ack", 32'(wr_ack), 32'(e_wr_ack));
        chk("disp_valid", 32'(disp_valid), 32'(e_disp_valid));
        chk("disp_q", 32'(disp_q), 32'(e_disp_q));
        chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
        chk("rd_data", 32'(rd_data), 32'(e_rd_data));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(e_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        disp_req = 0; rd_req = 0; wr_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [17:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 18'($urandom_range(0, 31));
            2:       return 18'($urandom_range(0, IMG_PIX - 1));
            default: return 18'($urandom_range(IMG_PIX - 8, 262143));
        endcase
    endfunction

    initial begin
        rst = 1; disp_addr = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset disp_valid", 32'(disp_valid), 32'd0);
        rst = 0;

        // Display stream: addr k requested at negedge k, returned 3 negedges later
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) chk("disp first latency", 32'(disp_valid), 32'd0);
            if (k >= 3) begin
                chk("disp stream valid", 32'(disp_valid), 32'd1);
                chk("disp stream data", 32'(disp_q), 32'(k - 3));
            end
            disp_req = 1;
            disp_addr = 18'(k);
        end

        // Write then read back
        @(negedge clk);
        disp_req = 0;
        wr_req = 1; wr_addr = 18'd1234; wr_data = 8'hA5;
        @(negedge clk);
        chk("wr ack", 32'(wr_ack), 32'd1);
        chk("wr mem_we", 32'(mem_we), 32'd1);
        chk("wr mem_addr", 32'(mem_addr), 32'd1234);
        wr_req = 0;
        @(negedge clk);
        chk("wr we pulse", 32'(mem_we), 32'd0);
        rd_req = 1; rd_addr = 18'd1234;
        @(negedge clk);
        chk("rd ack", 32'(rd_ack), 32'd1);
        rd_req = 0;
        @(negedge clk);
        chk("rd latency", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("rd valid", 32'(rd_valid), 32'd1);
        chk("rd data", 32'(rd_data), 32'hA5);

        // Contention: alternating acks, read first after reset
        do_reset();
        rd_req = 1; rd_addr = 18'd10;
        wr_req = 1; wr_addr = 18'd20; wr_data = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr rd_ack", 32'(rd_ack), 32'(i % 2 == 0));
            chk("rr wr_ack", 32'(wr_ack), 32'(i % 2 == 1));
        end
        idle_inputs();

        // Preemption by display
        do_reset();
        disp_req = 1; disp_addr = 18'd3;
        rd_req = 1; rd_addr = 18'd77;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("preempt no ack", 32'(rd_ack), 32'd0);
        end
        disp_req = 0;
        @(negedge clk);
        chk("preempt ack", 32'(rd_ack), 32'd1);
        chk("preempt conflicts", 32'(conflict_cnt), 32'd10);
        rd_req = 0;

        // Out of range accesses plus the last valid pixel
        wr_req = 1; wr_addr = 18'd160000; wr_data = 8'h33;
        @(negedge clk);
        chk("oor wr ack", 32'(wr_ack), 32'd1);
        chk("oor wr we", 32'(mem_we), 32'd0);
        wr_req = 0;
        rd_req = 1; rd_addr = 18'd200000;
        @(negedge clk);
        chk("oor rd ack", 32'(rd_ack), 32'd1);
        rd_addr = 18'd159999;
        @(negedge clk);
        chk("last pix rd ack", 32'(rd_ack), 32'd1);
        rd_req = 0;
        @(negedge clk);
        chk("oor rd valid", 32'(rd_valid), 32'd1);
        chk("oor rd zero", 32'(rd_data), 32'h00);
        @(negedge clk);
        chk("last pix valid", 32'(rd_valid), 32'd1);
        chk("last pix data", 32'(rd_data), 32'hFF);

        // Reset while a read is in flight
        rd_req = 1; rd_addr = 18'd5;
        @(negedge clk);
        chk("mid rd ack", 32'(rd_ack), 32'd1);
        rd_req = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid rst ack", 32'(rd_ack), 32'd0);
        chk("mid rst mem_addr", 32'(mem_addr), 32'd0);
        chk("mid rst conflicts", 32'(conflict_cnt), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mid rst no valid", 32'(rd_valid), 32'd0);
        end

        // Randomized traffic honouring the hold-until-ack handshake
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            disp_req = ($urandom_range(0, 9) < 3);
            disp_addr = rand_addr();
            if (!rd_req || rd_ack) begin
                rd_req = ($urandom_range(0, 1) == 1);
                rd_addr = rand_addr();
            end
            if (!wr_req || wr_ack) begin
                wr_req = ($urandom_range(0, 1) == 1);
                wr_addr = rand_addr();
                wr_data = 8'($urandom);
            end
        end
        @(negedge clk);
        rst = 0;
        idle_inputs();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/img_mem_arbiter.md
# img_mem_arbiter

Arbitrates the single-port 400x400 8-bit grayscale image memory (18-bit address) between three requesters: the VGA pixel fetch path (display), a processing-engine read port and an image-loader write port. The display has absolute priority so pixel timing never slips. The read and write ports share the remaining cycles round-robin. The block sits between the video generator and the image RAM, owns the RAM address, write-enable and write-data pins, and routes returning read data to the requester that issued it.

## Interface
- ADDR_W, 18, memory address width
- DATA_W, 8, pixel width
- IMG_WIDTH, 400, image width in pixels
- IMG_HEIGHT, 400, image height in pixels; valid addresses are 0 .. IMG_WIDTH*IMG_HEIGHT-1 (159999)

- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  display fetch request this cycle; no handshake
- disp_addr  in  ADDR_W  display fetch address
- disp_q  out  DATA_W  display pixel data
- disp_valid  out  1  disp_q holds data for a request sampled 2 edges earlier
- rd_req  in  1  engine read request
- rd_addr  in  ADDR_W  engine read address
- rd_ack  out  1  engine read accepted
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- rd_data  out  DATA_W  engine read data
- wr_req  in  1  loader write request
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- wr_ack  out  1  loader write accepted
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_q  in  DATA_W  RAM read data; 1-cycle synchronous read latency
- conflict_cnt  out  16  saturating count of cycles in which display preempted a pending rd_req or wr_req

## Operation
- Grant priority at each edge: disp_req first, then rd_req/wr_req by round-robin.
- Round-robin pointer last_rw:
  - When both rd_req and wr_req are pending and disp_req is low, grant the one not granted last.
  - last_rw updates only on an rd or wr grant.
  - Reset value of last_rw is "write", so the first contested grant goes to read.
- Grant actions:
  - Display grant: mem_addr <= disp_addr, mem_we <= 0, return tag DISP enters the tag pipe.
  - Read grant: mem_addr <= rd_addr, mem_we <= 0, rd_ack <= 1, tag RD.
  - Write grant: mem_addr <= wr_addr, mem_wdata <= wr_data, mem_we <= 1, wr_ack <= 1, tag NONE.
  - No grant: mem_we <= 0, mem_addr holds, tag NONE.
- Out-of-range address (>= 159999+1):
  - Write: acked normally but mem_we stays 0.
  - Read or display: issued with tag carrying a zero flag; returned data is forced to 0.
- Tag pipe is 2 stages. At stage 2, mem_q (or 0 if the zero flag is set) is registered:
  - into disp_q with disp_valid=1 for DISP;
  - into rd_data with rd_valid=1 for RD.
- disp_q and rd_data hold their last value otherwise. The valid strobes are single-cycle.
- Handshake: a requester holds req/addr/data stable until it sees ack high. If req is still high during the ack cycle, that is a new request and is arbitrated at the next edge, which gives back-to-back transfers at one per cycle.
- conflict_cnt increments on each edge where disp_req=1 and (rd_req or wr_req)=1, and saturates at 0xFFFF.

## Timing
- Request sampled at edge E0.
- RAM command (mem_addr/mem_we/mem_wdata) and rd_ack/wr_ack are visible after E0.
- RAM captures at E1; mem_q is valid after E1.
- disp_q/disp_valid and rd_data/rd_valid are registered at E2: read latency is 2 cycles, fixed.
- Write: RAM is updated at E1. A read of the same address granted at E1 or later returns the new data.
- rd_ack and wr_ack are one-cycle pulses; they are never both high in the same cycle.
- Reset values:
  - mem_addr=0, mem_we=0, mem_wdata=0
  - rd_ack=wr_ack=0, rd_valid=disp_valid=0
  - disp_q=rd_data=0, conflict_cnt=0
  - tag pipe cleared
- Reset mid-operation discards in-flight reads: no valid strobe follows reset for requests issued before it.

## Test plan
- Display only: disp_req=1 with addr 0,1,2… every cycle, RAM preloaded with value = addr[7:0] → disp_valid continuous from 2 cycles after the first request, disp_q = 0,1,2… in order.
- Write then read: wr_req addr 1234 data 0xA5 → wr_ack next cycle, mem_we=1 for one cycle. Then rd_req addr 1234 → rd_ack, and rd_valid 2 cycles later with rd_data=0xA5.
- Contention: rd_req and wr_req held for 6 cycles, disp_req low → acks alternate RD, WR, RD, WR…, starting with RD after reset.
- Preemption: disp_req held 10 cycles while rd_req is pending → no rd_ack during those cycles, conflict_cnt=10, rd_ack on the first cycle disp_req drops.
- Out of range: wr_req addr 160000 → wr_ack=1, mem_we stays 0. rd_req addr 200000 → rd_valid with rd_data=0x00.
- Reset mid-read: rd_req granted, rst asserted at E1 → no rd_valid afterwards, all outputs at reset values, conflict_cnt=0.
